// File: rtl/rst_tick_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rst_tick_pkg
// Description : Shared state encodings and width helper for rst_tick_seq.
// Revision    : 1.0 - initial release
// ============================================================================
package rst_tick_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] HOLD  = 2'd0;
    localparam logic [STATE_W-1:0] RUN   = 2'd1;
    localparam logic [STATE_W-1:0] DRAIN = 2'd2;

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rst_tick_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : rst_tick_seq_if
// Description : Control/status bundle between rst_tick_seq and its user.
// Revision    : 1.0 - initial release
// ============================================================================
interface rst_tick_seq_if #(
    parameter int TICK_DIV = 10
) ();

    localparam int CW = rst_tick_pkg::cnt_width(TICK_DIV);

    logic                              sw_rst_req;
    logic                              tick_en;
    logic                              sys_rst;
    logic                              rst_done;
    logic                              tick;
    logic [CW-1:0]                     tick_cnt;
    logic [rst_tick_pkg::STATE_W-1:0]  state;

    modport master (
        output sw_rst_req, tick_en,
        input  sys_rst, rst_done, tick, tick_cnt, state
    );

    modport slave (
        input  sw_rst_req, tick_en,
        output sys_rst, rst_done, tick, tick_cnt, state
    );

endinterface
`default_nettype wire

// File: rtl/rst_tick_seq_mod_cnt.sv
`default_nettype none
// ============================================================================
// Module      : mod_cnt
// Description : Modulo-MOD counter with enable, synchronous clear and
//               terminal-count flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_cnt #(
    parameter int MOD = 10,
    parameter int W   = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         i_en,
    input  wire logic         i_clr,
    output logic [W-1:0]      o_cnt,
    output logic              o_tc
);

    localparam logic [W-1:0] c_last = W'(MOD - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/rst_tick_seq.sv
`default_nettype none
// ============================================================================
// Module      : rst_tick_seq
// Description : Reset stretcher with software reset and a gated tick
//               generator that only runs once downstream reset has released.
// Revision    : 1.0 - initial release
// ============================================================================
module rst_tick_seq
    import rst_tick_pkg::*;
#(
    parameter int RST_STRETCH = 4,
    parameter int TICK_DIV    = 10
) (
    input  wire logic      clk,
    input  wire logic      rst,
    rst_tick_seq_if.slave  bus
);

    localparam int             CW          = cnt_width(TICK_DIV);
    localparam logic [7:0]     c_hold_last = 8'(RST_STRETCH - 1);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;
    logic [7:0]         r_hold_cnt;
    logic [7:0]         w_hold_nxt;
    logic               w_release;
    logic               r_sys_rst;
    logic               r_rst_done;
    logic               w_cnt_en;
    logic               w_cnt_clr;
    logic               w_tc;
    logic [CW-1:0]      w_tick_cnt;

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_release   = 1'b0;
        case (r_state)
            HOLD: begin
                if (bus.sw_rst_req) begin
                    w_hold_nxt = 8'd0;
                end else if (r_hold_cnt == c_hold_last) begin
                    w_state_nxt = RUN;
                    w_hold_nxt  = 8'd0;
                    w_release   = 1'b1;
                end else begin
                    w_hold_nxt = r_hold_cnt + 8'd1;
                end
            end
            RUN: begin
                w_hold_nxt = 8'd0;
                if (bus.sw_rst_req) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_state_nxt = HOLD;
                w_hold_nxt  = 8'd0;
            end
            default: begin
                w_state_nxt = HOLD;
                w_hold_nxt  = 8'd0;
            end
        endcase
    end

    // sys_rst follows the next state so it falls on the same edge RUN is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= HOLD;
            r_hold_cnt <= 8'd0;
            r_sys_rst  <= 1'b1;
            r_rst_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_sys_rst  <= (w_state_nxt != RUN);
            r_rst_done <= w_release;
        end
    end

    assign w_cnt_en  = (r_state == RUN) && bus.tick_en;
    assign w_cnt_clr = (r_state != RUN) || bus.sw_rst_req;

    mod_cnt #(
        .MOD (TICK_DIV),
        .W   (CW)
    ) u_tick_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_cnt_en),
        .i_clr (w_cnt_clr),
        .o_cnt (w_tick_cnt),
        .o_tc  (w_tc)
    );

    assign bus.tick     = w_cnt_en && w_tc && !rst;
    assign bus.tick_cnt = w_tick_cnt;
    assign bus.sys_rst  = r_sys_rst;
    assign bus.rst_done = r_rst_done;
    assign bus.state    = r_state;

endmodule
`default_nettype wire

// File: doc/rst_tick_seq.md
RST_TICK_SEQ -- requirements
Module: rst_tick_seq

Interface
REQ-001 Parameter RST_STRETCH, default 4: number of clk cycles sys_rst is held after the reset source releases; legal range 1..255.
REQ-002 Parameter TICK_DIV, default 10: tick period in clk cycles; legal range 2..2^16.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous reset, active-high, sampled on the clk rising edge.
REQ-005 sw_rst_req  input  1  software reset request; level-sampled, and each high cycle is treated as a request.
REQ-006 tick_en  input  1  tick counter enable; counting is frozen while low.
REQ-007 sys_rst  output  1  stretched synchronous active-high reset for downstream logic, registered.
REQ-008 rst_done  output  1  one-cycle pulse in the first cycle that sys_rst is low.
REQ-009 tick  output  1  one-cycle enable pulse every TICK_DIV enabled cycles in RUN.
REQ-010 tick_cnt  output  CW  current tick count, where CW = max(1, clog2(TICK_DIV)).
REQ-011 state  output  2  current FSM state, for debug.

Function
REQ-012 The block SHALL implement a three-state FSM: HOLD=2'd0, RUN=2'd1, DRAIN=2'd2; the encoding 2'd3 SHALL recover to HOLD on the next edge.
REQ-013 In HOLD, hold_cnt (8 bits) SHALL increment each edge while rst=0 and sw_rst_req=0.
REQ-014 In HOLD, when hold_cnt==RST_STRETCH-1 and an increment would occur, the FSM SHALL move to RUN, and sys_rst SHALL drop on that same edge.
REQ-015 sys_rst SHALL be high exactly RST_STRETCH cycles, counted from the first edge with rst=0.
REQ-016 sw_rst_req=1 in HOLD SHALL clear hold_cnt, restarting the stretch.
REQ-017 rst_done SHALL be high only in the single cycle following the HOLD->RUN edge.
REQ-018 In RUN with tick_en=1, tick_cnt SHALL increment by 1 and wrap from TICK_DIV-1 to 0.
REQ-019 In RUN with tick_en=0, tick_cnt SHALL hold its value.
REQ-020 tick SHALL be combinational: state==RUN, tick_en=1 and tick_cnt==TICK_DIV-1; it SHALL never be high outside RUN.
REQ-021 sw_rst_req=1 in RUN SHALL move the FSM to DRAIN, set sys_rst=1, and clear tick_cnt.
REQ-022 DRAIN SHALL last one cycle and then move to HOLD with hold_cnt=0; sw_rst_req in DRAIN SHALL be ignored.
REQ-023 When sw_rst_req=1 and tick would fire in the same cycle, tick SHALL still be asserted and the reset SHALL take effect on the next edge.
REQ-024 When RST_STRETCH=1, sys_rst SHALL drop one edge after rst releases.

Reset
REQ-025 rst=1 SHALL override all other inputs at any state or mid-count.
REQ-026 On rst=1 the block SHALL set: state=HOLD, hold_cnt=0, tick_cnt=0, sys_rst=1, rst_done=0.
REQ-027 tick SHALL be 0 while rst=1.
REQ-028 The block SHALL contain no asynchronous reset paths and no initial-value dependence.

Structure
REQ-029 The state encodings (HOLD, RUN, DRAIN) and the state width constant SHALL live in the shared package rst_tick_pkg.
REQ-030 The modulo-N counter with enable, synchronous clear and terminal-count flag SHALL be a sub-module, mod_cnt, instantiated for tick_cnt.
REQ-031 hold_cnt SHALL remain inline in the FSM.

Verification
REQ-032 Power-up: rst high 3 cycles then low, defaults -> sys_rst high for exactly 4 edges after release, rst_done pulses once, state=RUN.
REQ-033 Tick period: tick_en=1 in RUN for 30 cycles -> tick pulses at the 10th, 20th and 30th RUN cycles, and tick_cnt shows the 0..9 wrap.
REQ-034 Enable freeze: tick_en low for 5 cycles at tick_cnt=6 -> tick_cnt stays 6, and the next tick is delayed by exactly 5 cycles.
REQ-035 Software reset in RUN: sw_rst_req for 1 cycle at tick_cnt=3 -> DRAIN for 1 cycle, then HOLD, sys_rst high 1+4 cycles, tick_cnt=0, rst_done pulses again.
REQ-036 Stretch restart: sw_rst_req high at hold_cnt=2 in HOLD -> hold_cnt=0, and the release is delayed so that sys_rst drops 4 edges after sw_rst_req falls.
REQ-037 Reset mid-operation: rst for 1 cycle during RUN at tick_cnt=9 with tick_en=1 -> no tick in that cycle, all outputs at reset values, normal 4-cycle stretch follows.
